// File: rtl/clkgen_pkg.sv
// Shared types and constants for the phased clock generator.
package clkgen_pkg;

  // Generator operating state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  // Default counter/configuration width.
  localparam int DEF_CNT_W = 32;

  // Default divisor: 125 MHz reference down to 1 kHz.
  localparam int DEF_DIVISOR = 125000;

  // LSB position of channel ch inside a flat per-channel vector of width-bit slices.
  function automatic int phaseLsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/clkgen_channel.sv
// One output channel: distance from its phase point within the period,
// compared against the shared high time, then registered.
module clkgen_channel
  import clkgen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] high,
  input  logic [CNT_W-1:0] phase,
  output logic             clkOut
);

  logic [CNT_W:0] delta;
  logic           level;

  // Cycles since this channel's phase point, wrapped into [0, div); one extra bit keeps cnt + div exact.
  always_comb begin
    if (cnt >= phase) begin
      delta = {1'b0, cnt} - {1'b0, phase};
    end else begin
      delta = {1'b0, cnt} + {1'b0, div} - {1'b0, phase};
    end
    level = run && (delta < {1'b0, high});
  end

  // Registered output so the generated clock is glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clkOut <= 1'b0;
    end else begin
      clkOut <= level;
    end
  end

endmodule

// File: rtl/phased_clock_gen.sv
// Multi-channel phase-shifted clock generator: master period counter, control FSM,
// configuration validation and active/shadow configuration registers.
//
// Handshake: a configuration transfers on a cycle where cfg_valid && cfg_ready;
// cfg_ready depends only on state, never on cfg_valid. A transferred offer that
// fails validation is dropped and reported by a one-cycle cfg_error pulse.
module phased_clock_gen
  import clkgen_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIVISOR
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_divisor,
  input  logic [CNT_W-1:0]        cfg_high,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  output logic [NUM_CH-1:0]       clk_out,
  output logic                    period_tick,
  output logic                    cfg_error,
  output state_t                  debugState
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV / 2);

  state_t                  state;
  state_t                  nextState;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        activeDiv;
  logic [CNT_W-1:0]        activeHigh;
  logic [NUM_CH*CNT_W-1:0] activePh;
  logic [CNT_W-1:0]        shadowDiv;
  logic [CNT_W-1:0]        shadowHigh;
  logic [NUM_CH*CNT_W-1:0] shadowPh;
  logic                    cfgOk;
  logic                    transfer;
  logic                    accept;
  logic                    reject;
  logic                    atWrap;
  logic                    running;
  logic                    loadActiveFromOffer;
  logic                    loadActiveFromShadow;
  logic                    loadShadow;

  assign debugState = state;

  // Offer validation: divisor of at least 2, high time within the period, every phase inside the period.
  always_comb begin
    cfgOk = (cfg_divisor >= CNT_TWO) && (cfg_high <= cfg_divisor);
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_phase[phaseLsb(i, CNT_W) +: CNT_W] >= cfg_divisor) begin
        cfgOk = 1'b0;
      end
    end
  end

  // Handshake qualification and period-boundary detection.
  always_comb begin
    transfer = cfg_valid && cfg_ready;
    accept   = transfer && cfgOk;
    reject   = transfer && !cfgOk;
    atWrap   = (cnt == activeDiv - CNT_ONE);
    running  = (state != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // FSM next state: enable low always wins; a shadowed offer retires at the period wrap.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (enable) nextState = RUN;
      RUN:     if (!enable) nextState = IDLE;
               else if (accept) nextState = PENDING;
      PENDING: if (!enable) nextState = IDLE;
               else if (atWrap) nextState = RUN;
      default: nextState = IDLE;
    endcase
  end

  // FSM outputs: readiness and which configuration register loads this cycle.
  always_comb begin
    cfg_ready            = (state != PENDING);
    loadActiveFromOffer  = accept && ((state == IDLE) || !enable);
    loadShadow           = accept && (state == RUN) && enable;
    loadActiveFromShadow = (state == PENDING) && (!enable || atWrap);
  end

  // Master period counter: held at 0 when idle or stopping, wraps at div-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == IDLE) || !enable || atWrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Active configuration: direct load when idle or stopping, otherwise only from the shadow at a boundary.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      activeDiv  <= RST_DIV;
      activeHigh <= RST_HIGH;
      activePh   <= '0;
    end else if (loadActiveFromOffer) begin
      activeDiv  <= cfg_divisor;
      activeHigh <= cfg_high;
      activePh   <= cfg_phase;
    end else if (loadActiveFromShadow) begin
      activeDiv  <= shadowDiv;
      activeHigh <= shadowHigh;
      activePh   <= shadowPh;
    end
  end

  // Shadow configuration: holds an accepted offer until the running period ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadowDiv  <= '0;
      shadowHigh <= '0;
      shadowPh   <= '0;
    end else if (loadShadow) begin
      shadowDiv  <= cfg_divisor;
      shadowHigh <= cfg_high;
      shadowPh   <= cfg_phase;
    end
  end

  // Registered status pulses: period start (aligned with clk_out for cnt 0) and rejected offer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      period_tick <= 1'b0;
      cfg_error   <= 1'b0;
    end else begin
      period_tick <= running && (cnt == '0);
      cfg_error   <= reject;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gChannel
    clkgen_channel #(
      .CNT_W(CNT_W)
    ) uChannel (
      .clock  (clock),
      .reset  (reset),
      .run    (running),
      .cnt    (cnt),
      .div    (activeDiv),
      .high   (activeHigh),
      .phase  (activePh[phaseLsb(i, CNT_W) +: CNT_W]),
      .clkOut (clk_out[i])
    );
  end

endmodule

// File: tb/tb_phased_clock_gen.sv
// Bench for phased_clock_gen: directed scenarios with hand-computed expectations
// plus randomized traffic, all checked every cycle against a period/position model.
module tb_phased_clock_gen;
  import clkgen_pkg::*;

  localparam int NUM_CH = 8;
  localparam int CNT_W  = 32;
  localparam int DEF    = 125000;

  // ---------------- clock / reset ----------------
  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    enable = 1'b0;
  logic                    cfg_valid = 1'b0;
  logic                    cfg_ready;
  logic [CNT_W-1:0]        cfg_divisor = '0;
  logic [CNT_W-1:0]        cfg_high = '0;
  logic [NUM_CH*CNT_W-1:0] cfg_phase = '0;
  logic [NUM_CH-1:0]       clk_out;
  logic                    period_tick;
  logic                    cfg_error;
  state_t                  debugState;

  always #4 clock = ~clock;

  int cycleNo = 0;
  always @(posedge clock) cycleNo++;

  phased_clock_gen #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_divisor (cfg_divisor),
    .cfg_high    (cfg_high),
    .cfg_phase   (cfg_phase),
    .clk_out     (clk_out),
    .period_tick (period_tick),
    .cfg_error   (cfg_error),
    .debugState  (debugState)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks "running?", "position in period" and the active/pending settings.
  // Each channel is high while ((pos - phase) mod div) < high.
  longint mDiv, mHigh, mPos, sDiv, sHigh;
  longint mPh[NUM_CH];
  longint sPh[NUM_CH];
  longint oDiv, oHigh;
  longint oPh[NUM_CH];
  bit     mRun, mPend, offered, offerOk, wrap;
  logic [NUM_CH-1:0] eClk;
  logic [NUM_CH+2:0] exp_q[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mDiv = DEF; mHigh = DEF / 2; mPos = 0; mRun = 0; mPend = 0;
      sDiv = 0; sHigh = 0;
      for (int c = 0; c < NUM_CH; c++) begin mPh[c] = 0; sPh[c] = 0; end
      exp_q.delete();
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        eClk[c] = mRun && (((mPos - mPh[c] + mDiv) % mDiv) < mHigh);
      oDiv = longint'(cfg_divisor);
      oHigh = longint'(cfg_high);
      offerOk = (oDiv >= 2) && (oHigh <= oDiv);
      for (int c = 0; c < NUM_CH; c++) begin
        oPh[c] = longint'(cfg_phase[c*CNT_W +: CNT_W]);
        if (oPh[c] >= oDiv) offerOk = 0;
      end
      offered = cfg_valid && !mPend;
      // error pulse belongs to this edge, ready to the state after it
      exp_q.push_back({1'b0, offered && !offerOk, mRun && (mPos == 0), eClk});
      if (!enable) begin
        if (offered && offerOk) begin
          mDiv = oDiv; mHigh = oHigh; mPh = oPh;
        end else if (mPend) begin
          mDiv = sDiv; mHigh = sHigh; mPh = sPh;
        end
        mRun = 0; mPend = 0; mPos = 0;
      end else if (!mRun) begin
        if (offered && offerOk) begin
          mDiv = oDiv; mHigh = oHigh; mPh = oPh;
        end
        mRun = 1; mPos = 0;
      end else begin
        wrap = (mPos == mDiv - 1);
        mPos = wrap ? 0 : mPos + 1;
        if (mPend && wrap) begin
          mDiv = sDiv; mHigh = sHigh; mPh = sPh; mPend = 0;
        end else if (offered && offerOk) begin
          sDiv = oDiv; sHigh = oHigh; sPh = oPh; mPend = 1;
        end
      end
      exp_q[exp_q.size()-1][NUM_CH+2] = !mPend;
    end
  end

  // ---------------- scoreboard compare ----------------
  logic [NUM_CH+2:0] e;
  always @(negedge clock) begin
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("clk_out",     64'(clk_out),     64'(e[NUM_CH-1:0]));
      check("period_tick", 64'(period_tick), 64'(e[NUM_CH]));
      check("cfg_error",   64'(cfg_error),   64'(e[NUM_CH+1]));
      check("cfg_ready",   64'(cfg_ready),   64'(e[NUM_CH+2]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic offer(input longint d, input longint h, input longint p0,
                       input longint p1, input longint p2);
    bit r;
    cfg_divisor = 32'(d);
    cfg_high    = 32'(h);
    cfg_phase   = '0;
    cfg_phase[0 +: CNT_W]       = 32'(p0);
    cfg_phase[CNT_W +: CNT_W]   = 32'(p1);
    cfg_phase[2*CNT_W +: CNT_W] = 32'(p2);
    cfg_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = cfg_ready;
      @(posedge clock);
      #1;
      if (r) begin
        cfg_valid = 1'b0;
        return;
      end
    end
    cfg_valid = 1'b0;
    check("offer_timeout", 64'(1), 64'(0));
  endtask

  task automatic waitTick(input int bound, output int n);
    n = 0;
    while (1) begin
      @(negedge clock);
      n++;
      if (period_tick === 1'b1) return;
      if (n >= bound) begin
        check("tick_timeout", 64'(n), 64'(0));
        return;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int n, t0, ones, toggles, d, h, p;
  logic [NUM_CH-1:0] accOr, accAnd;
  logic prev;
  logic [2:0] want;

  initial begin
    // reset state
    repeat (3) @(negedge clock);
    check("rst_clk_out", 64'(clk_out), 64'(0));
    check("rst_tick",    64'(period_tick), 64'(0));
    check("rst_error",   64'(cfg_error), 64'(0));
    check("rst_ready",   64'(cfg_ready), 64'(1));
    check("rst_state",   64'(debugState), 64'(IDLE));
    @(posedge clock); #1;
    reset = 1'b0;
    step(2);

    // defaults: first tick one cycle after enable is sampled, all channels high at cnt 0
    enable = 1'b1;
    waitTick(10, n);
    check("first_tick_latency", 64'(n), 64'(3));
    check("default_clk_at_0", 64'(clk_out), 64'(8'hFF));
    step(300);
    check("default_still_high", 64'(clk_out), 64'(8'hFF));

    // stop
    enable = 1'b0;
    step(2);
    check("idle_clk_out", 64'(clk_out), 64'(0));
    check("idle_state", 64'(debugState), 64'(IDLE));

    // IDLE configuration div 10, high 5, ph1 3, ph2 9
    offer(10, 5, 0, 3, 9);
    enable = 1'b1;
    waitTick(20, n);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clock);
      want[0] = (k <= 4);
      want[1] = (k >= 3) && (k <= 7);
      want[2] = (k == 9) || (k <= 3);
      check("idle_cfg_pattern", 64'(clk_out[2:0]), 64'(want));
    end
    waitTick(20, n);
    check("period_10", 64'(n), 64'(1));  // the tick directly follows the cnt=9 sample
    waitTick(20, n);
    check("period_10_gap", 64'(n), 64'(10));

    // live change to div 6 / high 2 mid-period
    t0 = cycleNo;
    step(3);
    offer(6, 2, 0, 0, 0);
    check("pending_not_ready", 64'(cfg_ready), 64'(0));
    check("pending_state", 64'(debugState), 64'(PENDING));
    waitTick(20, n);
    check("old_period_intact", 64'(cycleNo - t0), 64'(10));
    t0 = cycleNo;
    ones = int'(clk_out[0]);
    for (int k = 1; k < 6; k++) begin
      @(negedge clock);
      ones += int'(clk_out[0]);
    end
    check("new_high_time", 64'(ones), 64'(2));
    check("ready_back", 64'(cfg_ready), 64'(1));
    waitTick(20, n);
    check("new_period_6", 64'(cycleNo - t0), 64'(6));

    // invalid offer: high 11 > div 10
    offer(10, 11, 0, 0, 0);
    @(negedge clock);
    check("error_pulse", 64'(cfg_error), 64'(1));
    check("error_state", 64'(debugState), 64'(RUN));
    @(negedge clock);
    check("error_one_cycle", 64'(cfg_error), 64'(0));
    waitTick(20, n);
    t0 = cycleNo;
    waitTick(20, n);
    check("period_kept_6", 64'(cycleNo - t0), 64'(6));

    // high 0 -> constant 0
    offer(8, 0, 0, 3, 7);
    waitTick(40, n);
    waitTick(40, n);
    accOr = clk_out;
    for (int k = 1; k < 8; k++) begin
      @(negedge clock);
      accOr |= clk_out;
    end
    check("high0_const0", 64'(accOr), 64'(0));

    // high = div -> constant 1
    offer(8, 8, 1, 3, 7);
    waitTick(40, n);
    waitTick(40, n);
    accAnd = clk_out;
    for (int k = 1; k < 8; k++) begin
      @(negedge clock);
      accAnd &= clk_out;
    end
    check("highdiv_const1", 64'(accAnd), 64'(8'hFF));

    // div 2, high 1 -> toggles every cycle
    offer(2, 1, 0, 1, 0);
    waitTick(40, n);
    waitTick(40, n);
    check("div2_start_high", 64'(clk_out[0]), 64'(1));
    prev = clk_out[0];
    toggles = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (clk_out[0] !== prev) toggles++;
      prev = clk_out[0];
    end
    check("div2_toggles", 64'(toggles), 64'(6));
    waitTick(10, n);
    check("div2_tick_gap", 64'(n), 64'(2));

    // reset while PENDING
    offer(20, 10, 0, 0, 0);
    waitTick(40, n);
    waitTick(40, n);
    step(2);
    offer(5, 1, 0, 0, 0);
    check("pre_reset_pending", 64'(debugState), 64'(PENDING));
    #1 reset = 1'b1;
    #1;
    check("reset_clk_out", 64'(clk_out), 64'(0));
    check("reset_ready", 64'(cfg_ready), 64'(1));
    check("reset_state", 64'(debugState), 64'(IDLE));
    @(posedge clock); #1;
    reset = 1'b0;
    waitTick(10, n);
    check("after_reset_default", 64'(clk_out), 64'(8'hFF));
    repeat (8) @(negedge clock);
    check("shadow_discarded", 64'(clk_out), 64'(8'hFF));

    // enable low mid-period
    step(3);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    check("disable_clk_out", 64'(clk_out), 64'(0));

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 24) != 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 12));
      h = int'($urandom_range(0, d + 1));
      cfg_divisor = 32'(d);
      cfg_high    = 32'(h);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if ($urandom_range(0, 15) == 0 || d == 0) p = int'($urandom_range(0, d + 2));
        else p = int'($urandom_range(0, d - 1));
        cfg_phase[ch*CNT_W +: CNT_W] = 32'(p);
      end
      step(1);
    end
    cfg_valid = 1'b0;
    enable = 1'b1;
    step(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
